// File: rtl/fifo_write_arb_if.sv
// Write-request bundle between the three packet sources and the event FIFO
// arbiter. WIDTH is the packet width including parity; the carried data is
// WIDTH-1 bits.
interface fifo_write_arb_if #(
    parameter int WIDTH = 64
);
    logic [2:0]       req;
    logic [WIDTH-2:0] req_data0;
    logic [WIDTH-2:0] req_data1;
    logic [WIDTH-2:0] req_data2;
    logic             fifo_full;
    logic [2:0]       grant_ack;
    logic             dropped;
    logic [WIDTH-2:0] fifo_data;
    logic             write_fifo_n;

    // Requesters plus FIFO side (drives requests and fifo_full)
    modport master (
        output req, req_data0, req_data1, req_data2, fifo_full,
        input  grant_ack, dropped, fifo_data, write_fifo_n
    );

    // Arbiter side
    modport slave (
        input  req, req_data0, req_data1, req_data2, fifo_full,
        output grant_ack, dropped, fifo_data, write_fifo_n
    );
endinterface

// File: rtl/fifo_write_arb.sv
// Event FIFO write arbiter: three 4-phase requesters share one FIFO write
// port. Local events (req[0]) are dropped after STALL_LIMIT consecutive
// full-stall cycles; the other two requesters wait indefinitely.
// Optional feature: define FIFO_ARB_ROUND_ROBIN_EN for round-robin winner
// selection; otherwise fixed priority 2 > 1 > 0.
module fifo_write_arb #(
    parameter int WIDTH       = 64,
    parameter int STALL_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_write_arb_if.slave      bus,
    output logic [7:0]           drop_count,
    output logic                 arb_busy
);
    localparam int SCW = (STALL_LIMIT < 16) ? 4 : $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, WRITE, RELEASE} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       winner_reg, winner_next;
    logic [SCW-1:0]   stall_reg, stall_next;
    logic [WIDTH-2:0] fifo_data_reg;
    logic             write_n_reg;
    logic [2:0]       grant_reg;
    logic             dropped_reg;
    logic [7:0]       drop_count_reg;
    logic [1:0]       sel_idx;
    logic             load_data;
    logic             drop_now;
    logic [WIDTH-2:0] req_data_arr [3];

    assign req_data_arr[0] = bus.req_data0;
    assign req_data_arr[1] = bus.req_data1;
    assign req_data_arr[2] = bus.req_data2;

`ifdef FIFO_ARB_ROUND_ROBIN_EN
    logic [1:0] pointer_reg;
    logic       found;

    // Cyclic search starting just after the last granted index
    always_comb begin
        int cand;
        sel_idx = 2'd0;
        found   = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cand = (int'(pointer_reg) + k) % 3;
            if (!found && bus.req[cand]) begin
                sel_idx = 2'(cand);
                found   = 1'b1;
            end
        end
    end

    // Pointer follows every grant, drops included
    always_ff @(posedge clk) begin
        if (reset) begin
            pointer_reg <= 2'd2;
        end else if (load_data) begin
            pointer_reg <= sel_idx;
        end else if (drop_now) begin
            pointer_reg <= 2'd0;
        end
    end
`else
    // Fixed priority: config-read reply, then rx pass-along, then local event
    always_comb begin
        if (bus.req[2])      sel_idx = 2'd2;
        else if (bus.req[1]) sel_idx = 2'd1;
        else                 sel_idx = 2'd0;
    end
`endif

    // Next-state, winner capture and drop decision
    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        load_data   = 1'b0;
        drop_now    = 1'b0;
        case (state_reg)
            IDLE: begin
                // Selection wins over a drop; they cannot coincide anyway
                // because a drop needs fifo_full high.
                if ((|bus.req) && !bus.fifo_full) begin
                    state_next  = WRITE;
                    winner_next = sel_idx;
                    load_data   = 1'b1;
                end else if (bus.fifo_full && bus.req[0] &&
                             stall_reg == SCW'(STALL_LIMIT)) begin
                    state_next  = RELEASE;
                    winner_next = 2'd0;
                    drop_now    = 1'b1;
                end
            end
            WRITE:   state_next = RELEASE;
            RELEASE: if (!bus.req[winner_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stall counter: counts IDLE cycles with the local event blocked by a full FIFO
    always_comb begin
        stall_next = stall_reg;
        if (load_data || drop_now || !bus.req[0] || !bus.fifo_full) begin
            stall_next = '0;
        end else if (state_reg == IDLE) begin
            stall_next = stall_reg + SCW'(1);
        end
    end

    // State, data latch and registered strobes (one cycle behind WRITE)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            winner_reg     <= 2'd0;
            stall_reg      <= '0;
            fifo_data_reg  <= '0;
            write_n_reg    <= 1'b1;
            grant_reg      <= 3'b000;
            dropped_reg    <= 1'b0;
            drop_count_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            winner_reg  <= winner_next;
            stall_reg   <= stall_next;
            if (load_data) begin
                fifo_data_reg <= req_data_arr[sel_idx];
            end
            write_n_reg <= (state_reg != WRITE);
            if (state_reg == WRITE) begin
                grant_reg <= 3'b001 << winner_reg;
            end else if (drop_now) begin
                grant_reg <= 3'b001;
            end else begin
                grant_reg <= 3'b000;
            end
            dropped_reg <= drop_now;
            if (drop_now && drop_count_reg != 8'd255) begin
                drop_count_reg <= drop_count_reg + 8'd1;
            end
        end
    end

    assign bus.fifo_data    = fifo_data_reg;
    assign bus.write_fifo_n = write_n_reg;
    assign bus.grant_ack    = grant_reg;
    assign bus.dropped      = dropped_reg;
    assign drop_count       = drop_count_reg;
    assign arb_busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_fifo_write_arb.sv
// Self-checking bench for fifo_write_arb: a per-cycle vector table covering
// reset, a single write and three competing requesters, followed by hand
// sequences for local-event drops, an indefinitely stalled rx request and a
// reset landing in WRITE.
module tb_fifo_write_arb;
    localparam int WIDTH = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] drop_count;
    logic       arb_busy;

    fifo_write_arb_if #(.WIDTH(WIDTH)) bus ();

    fifo_write_arb #(.WIDTH(WIDTH), .STALL_LIMIT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .drop_count (drop_count),
        .arb_busy   (arb_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [2:0]    req;
        logic          full;
        logic          exp_wn;
        logic [2:0]    exp_grant;
        logic          exp_drop;
        logic [62:0]   exp_data;
        logic          exp_busy;
    } vec_t;

    vec_t        vecs [$];
    int          checks = 0;
    int          errors = 0;
    logic [62:0] dat [3];
    int          ord [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic rst, input logic [2:0] req, input logic full,
                                input logic wn, input logic [2:0] g, input logic dr,
                                input logic [62:0] d, input logic busy);
        vec_t v;
        v.rst = rst; v.req = req; v.full = full; v.exp_wn = wn; v.exp_grant = g;
        v.exp_drop = dr; v.exp_data = d; v.exp_busy = busy;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        bus.req = 3'b000;
        bus.fifo_full = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] mask;
        int         writes;
        int         edges;
        int         drops_seen;
        logic       seen;

        dat[0] = 63'h1234;
        dat[1] = 63'h5555_0001;
        dat[2] = 63'h7aaa_0002;
`ifdef FIFO_ARB_ROUND_ROBIN_EN
        ord = '{0, 1, 2};
`else
        ord = '{2, 1, 0};
`endif
        reset = 1'b1;
        bus.req = 3'b000;
        bus.fifo_full = 1'b0;
        bus.req_data0 = dat[0];
        bus.req_data1 = dat[1];
        bus.req_data2 = dat[2];

        // Reset state, then one local write with 2-cycle strobe latency
        add(1, 3'b000, 0, 1, 3'b000, 0, 63'h0,  0);
        add(0, 3'b001, 0, 1, 3'b000, 0, dat[0], 1);
        add(0, 3'b001, 0, 0, 3'b001, 0, dat[0], 1);
        add(0, 3'b000, 0, 1, 3'b000, 0, dat[0], 0);
        add(0, 3'b000, 0, 1, 3'b000, 0, dat[0], 0);
        // Fresh reset, then all three request; each holds until its ack
        add(1, 3'b000, 0, 1, 3'b000, 0, 63'h0,  0);
        mask = 3'b111;
        for (int i = 0; i < 3; i++) begin
            add(0, mask, 0, 1, 3'b000, 0, dat[ord[i]], 1);
            add(0, mask, 0, 0, 3'b001 << ord[i], 0, dat[ord[i]], 1);
            mask = mask & ~(3'b001 << ord[i]);
            add(0, mask, 0, 1, 3'b000, 0, dat[ord[i]], 0);
        end

        writes = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            bus.req = vecs[i].req;
            bus.fifo_full = vecs[i].full;
            tick();
            $display("vec %0d: req=%b wn=%b grant=%b drop=%b data=%0h busy=%b",
                     i, vecs[i].req, bus.write_fifo_n, bus.grant_ack, bus.dropped,
                     bus.fifo_data, arb_busy);
            chk($sformatf("v%0d_write_fifo_n", i), 64'(bus.write_fifo_n), 64'(vecs[i].exp_wn));
            chk($sformatf("v%0d_grant_ack", i), 64'(bus.grant_ack), 64'(vecs[i].exp_grant));
            chk($sformatf("v%0d_dropped", i), 64'(bus.dropped), 64'(vecs[i].exp_drop));
            chk($sformatf("v%0d_fifo_data", i), 64'(bus.fifo_data), 64'(vecs[i].exp_data));
            chk($sformatf("v%0d_arb_busy", i), 64'(arb_busy), 64'(vecs[i].exp_busy));
            if (i >= 6 && !bus.write_fifo_n) writes++;
        end
        reset = 1'b0;
        chk("three_writes", 64'(writes), 64'd3);

        // Local event stalled by a full FIFO is dropped after 15 stall cycles
        do_reset();
        chk("reset_drop_count", 64'(drop_count), 64'd0);
        bus.fifo_full = 1'b1;
        bus.req = 3'b001;
        edges = 0; seen = 1'b0; writes = 0;
        while (!seen && edges < 40) begin
            tick();
            edges++;
            if (!bus.write_fifo_n) writes++;
            if (bus.dropped) seen = 1'b1;
        end
        $display("drop 1: after %0d edges grant=%b count=%0d", edges, bus.grant_ack, drop_count);
        chk("drop_latency", 64'(edges), 64'd16);
        chk("drop_grant", 64'(bus.grant_ack), 64'b001);
        chk("drop_count_1", 64'(drop_count), 64'd1);
        chk("drop_no_write", 64'(writes), 64'd0);
        tick();
        chk("drop_pulse_one_cycle", 64'(bus.dropped), 64'd0);

        // 299 more drops; counter must saturate at 255
        drops_seen = 1;
        for (int n = 2; n <= 300; n++) begin
            bus.req = 3'b000;
            tick();
            bus.req = 3'b001;
            edges = 0; seen = 1'b0;
            while (!seen && edges < 40) begin
                tick();
                edges++;
                if (!bus.write_fifo_n) writes++;
                if (bus.dropped) seen = 1'b1;
            end
            if (!seen) begin
                chk($sformatf("drop_%0d_timeout", n), 64'(edges), 64'd16);
                break;
            end
            drops_seen++;
        end
        $display("drops: %0d total, drop_count=%0d", drops_seen, drop_count);
        chk("drops_seen", 64'(drops_seen), 64'd300);
        chk("drop_count_sat", 64'(drop_count), 64'd255);
        chk("drops_no_write", 64'(writes), 64'd0);

        // rx pass-along waits through 100 full cycles and is never dropped
        bus.req = 3'b000;
        tick();
        bus.req = 3'b010;
        edges = 0; writes = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.dropped || bus.grant_ack != 3'b000) edges++;
            if (!bus.write_fifo_n) writes++;
        end
        chk("rx_stall_no_ack", 64'(edges), 64'd0);
        chk("rx_stall_no_write", 64'(writes), 64'd0);
        bus.fifo_full = 1'b0;
        tick();
        chk("rx_write_cyc1_wn", 64'(bus.write_fifo_n), 64'd1);
        chk("rx_write_cyc1_busy", 64'(arb_busy), 64'd1);
        tick();
        $display("rx write: wn=%b grant=%b data=%0h", bus.write_fifo_n, bus.grant_ack, bus.fifo_data);
        chk("rx_write_wn", 64'(bus.write_fifo_n), 64'd0);
        chk("rx_write_grant", 64'(bus.grant_ack), 64'b010);
        chk("rx_write_data", 64'(bus.fifo_data), 64'(dat[1]));
        chk("rx_drop_count_kept", 64'(drop_count), 64'd255);
        bus.req = 3'b000;
        tick();

        // Reset pulse while in WRITE aborts the write; req still high re-arbitrates
        do_reset();
        bus.req = 3'b001;
        tick();
        chk("abort_in_write_busy", 64'(arb_busy), 64'd1);
        reset = 1'b1;
        tick();
        chk("abort_wn", 64'(bus.write_fifo_n), 64'd1);
        chk("abort_grant", 64'(bus.grant_ack), 64'd0);
        chk("abort_busy", 64'(arb_busy), 64'd0);
        reset = 1'b0;
        tick();
        chk("rearb_cyc1_wn", 64'(bus.write_fifo_n), 64'd1);
        chk("rearb_cyc1_grant", 64'(bus.grant_ack), 64'd0);
        tick();
        $display("re-arb write: wn=%b grant=%b data=%0h", bus.write_fifo_n, bus.grant_ack, bus.fifo_data);
        chk("rearb_wn", 64'(bus.write_fifo_n), 64'd0);
        chk("rearb_grant", 64'(bus.grant_ack), 64'b001);
        chk("rearb_data", 64'(bus.fifo_data), 64'(dat[0]));
        bus.req = 3'b000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_write_arb.md
FIFO_WRITE_ARB -- requirements
Module: fifo_write_arb

Interface
REQ-001 Parameter WIDTH, default 64, packet width including parity; the data path is WIDTH-1 bits.
REQ-002 Parameter STALL_LIMIT, default 15, number of consecutive full-stall cycles before a local event is dropped.
REQ-003 clk  input  1  primary clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  3  write requests: [0] local event router, [1] rx pass-along, [2] config-read reply; level, 4-phase.
REQ-006 req_data0, req_data1, req_data2  input  WIDTH-1 each  packet offered by each requester.
REQ-007 fifo_full  input  1  high when the event FIFO cannot accept a write.
REQ-008 grant_ack  output  3  one-cycle pulse; the indexed requester's packet was written or dropped.
REQ-009 dropped  output  1  one-cycle pulse coincident with grant_ack[0] when the packet was discarded, not written.
REQ-010 fifo_data  output  WIDTH-1  packet presented to the FIFO write port.
REQ-011 write_fifo_n  output  1  FIFO write strobe, active low, one cycle.
REQ-012 drop_count  output  8  number of dropped local events, saturating.
REQ-013 arb_busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WRITE and RELEASE.
REQ-015 In IDLE with any req bit high and fifo_full low, the block SHALL select one winner, latch its req_data into fifo_data and go to WRITE on the next edge.
REQ-016 In WRITE, write_fifo_n SHALL be 0 and grant_ack[winner] SHALL be 1 for exactly one cycle, then the FSM goes to RELEASE.
REQ-017 Write latency from req rising (FIFO not full, no competitor) to write_fifo_n low SHALL be 2 cycles; registered outputs mean req is sampled in cycle 0, the FSM is in WRITE in cycle 1 and write_fifo_n is low in cycle 2.
REQ-018 In RELEASE, the FSM SHALL stay until req[winner] is low, then return to IDLE; other requests are not serviced meanwhile.
REQ-019 fifo_data SHALL hold its last value outside WRITE; write_fifo_n SHALL be 1 outside WRITE.
REQ-020 If fifo_full rises while in WRITE, the write SHALL still complete; fifo_full is sampled only in IDLE.
REQ-021 A stall counter (4 bits minimum) SHALL increment each IDLE cycle in which fifo_full=1 and req[0]=1.
REQ-022 The stall counter SHALL clear on any grant, when req[0]=0, or when fifo_full=0.
REQ-023 When the stall counter equals STALL_LIMIT, the block SHALL pulse grant_ack[0] and dropped together, increment drop_count and go to RELEASE, with no FIFO write.
REQ-024 drop_count SHALL saturate at 255 and never wrap.
REQ-025 Requests 1 and 2 SHALL never be dropped; they wait indefinitely while fifo_full=1.
REQ-026 Simultaneous winner selection and drop condition in one cycle is impossible by construction, because a drop requires fifo_full=1; selection SHALL take precedence if both are evaluated.

Reset
REQ-027 When reset is sampled high, state SHALL become IDLE, with write_fifo_n=1, grant_ack=0, dropped=0, fifo_data=0, drop_count=0, stall counter=0, arb_busy=0 and the round-robin pointer=2, from the next edge.
REQ-028 A reset asserted in WRITE or RELEASE SHALL abort the transaction without a grant_ack pulse; the requester keeps req high and is re-arbitrated.

Configuration
REQ-029 With macro FIFO_ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first requesting index searched cyclically starting after the last granted index; the pointer updates on each grant, including drops.
REQ-030 Without FIFO_ARB_ROUND_ROBIN_EN, the winner SHALL be fixed priority 2 > 1 > 0 and no pointer is implemented.

Verification
REQ-031 After reset, set req=3'b001 with req_data0=63'h1234 and fifo_full=0 -> write_fifo_n low 2 cycles later, fifo_data=63'h1234, grant_ack=3'b001 in the same cycle.
REQ-032 Set req=3'b111 and hold each req until its ack (fixed priority build) -> grants in order 2, 1, 0, with exactly three write strobes.
REQ-033 Same stimulus with FIFO_ARB_ROUND_ROBIN_EN defined, starting from reset -> grants in order 0, 1, 2.
REQ-034 Set fifo_full=1 and req=3'b001 with STALL_LIMIT=15 -> dropped and grant_ack[0] pulse after 15 stall cycles, no write, drop_count=1; 300 drops -> drop_count=255.
REQ-035 Set fifo_full=1 and req=3'b010 for 100 cycles, then fifo_full=0 -> no drop, write_fifo_n low 2 cycles after the release, drop_count unchanged.
REQ-036 Pulse reset high for one cycle while in WRITE -> write_fifo_n=1 and no grant_ack pulse; with req still high, the write completes 2 cycles after reset falls.
